// File: rtl/training_symbol_injector_mc_pkg.sv
// tsi_pkg: shared mode/state types and sideband flag position for the training symbol injector
package tsi_pkg;
  typedef enum logic [1:0] {
    TSI_BYPASS = 2'b00,
    TSI_INJECT = 2'b01,
    TSI_ONCE   = 2'b10,
    TSI_RSVD   = 2'b11
  } tsiMode_t;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD
  } tsiState_t;
  localparam int TS_FLAG_BIT = 0;
endpackage

// File: rtl/training_symbol_injector_mc_skid.sv
// axis_skid_buf: 2-entry registered AXI-Stream stage, full throughput, stable under backpressure
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic [W-1:0] sData,
  input  logic         sValid,
  output logic         sReady,
  output logic [W-1:0] mData,
  output logic         mValid,
  input  logic         mReady
);
  logic         skValid;
  logic [W-1:0] skData;
  assign sReady = !skValid;
  // Output slot refills from the skid slot first; skid only catches a beat while the output is stalled
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mValid  <= 1'b0;
      mData   <= '0;
      skValid <= 1'b0;
      skData  <= '0;
    end else if (!mValid || mReady) begin
      mValid  <= skValid || sValid;
      mData   <= skValid ? skData : sData;
      skValid <= 1'b0;
    end else if (sValid && !skValid) begin
      skValid <= 1'b1;
      skData  <= sData;
    end
  end
endmodule

// File: rtl/training_symbol_injector_mc.sv
// training_symbol_injector_mc: prepends a RAM-held training sequence to AXI-Stream frames
module training_symbol_injector_mc
  import tsi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int USER_W   = 8,
  parameter int TS_DEPTH = 64,
  parameter int REP_W    = 4,
  localparam int AW      = $clog2(TS_DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [1:0]        cfg_mode,
  input  logic [AW:0]       cfg_ts_len,
  input  logic [REP_W-1:0]  cfg_ts_reps,
  input  logic              ts_wr_en,
  input  logic [AW-1:0]     ts_wr_addr,
  input  logic [DATA_W-1:0] ts_wr_data,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              cfg_err
);
  localparam int SW = DATA_W + USER_W + 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(TS_DEPTH);
  localparam logic [USER_W-1:0] TS_USER = USER_W'(1) << TS_FLAG_BIT;
  logic [DATA_W-1:0] tsRam [TS_DEPTH];
  tsiState_t         state, stateNext;
  tsiMode_t          cfgMode;
  logic [AW-1:0]     rdAddr, lenM1;
  logic [REP_W-1:0]  rdRep, repsM1;
  logic [AW:0]       lenClamp;
  logic [DATA_W-1:0] ramQ;
  logic [1:0]        prevMode;
  logic              modeOnce, onceDone, issDone, tsValid, tsLast;
  logic              injMode, lenZero, lenOver, cfgIllegal, injDue;
  logic              start, push, issue, beatIn, atEnd, lastWord;
  logic              skInValid, skInReady;
  logic [SW-1:0]     skInData, skOutData;
  assign cfgMode    = tsiMode_t'(cfg_mode);
  assign injMode    = cfgMode == TSI_INJECT || cfgMode == TSI_ONCE;
  assign lenZero    = cfg_ts_len == '0;
  assign lenOver    = cfg_ts_len > DEPTH_L;
  assign lenClamp   = lenOver ? DEPTH_L : cfg_ts_len;
  assign cfgIllegal = cfgMode == TSI_RSVD || (injMode && (lenZero || lenOver));
  assign injDue     = !lenZero && (cfgMode == TSI_INJECT || (cfgMode == TSI_ONCE && !onceDone));
  assign start      = state == ST_IDLE && s_axis_tvalid;
  assign push       = state == ST_PREAMBLE && tsValid && skInReady;
  assign issue      = state == ST_PREAMBLE && !issDone && (!tsValid || skInReady);
  assign beatIn     = state == ST_PAYLOAD && s_axis_tvalid && skInReady;
  assign atEnd      = rdAddr == lenM1;
  assign lastWord   = atEnd && rdRep == repsM1;
  assign busy          = state != ST_IDLE;
  assign s_axis_tready = state == ST_PAYLOAD && skInReady;
  assign skInValid     = (state == ST_PREAMBLE) ? tsValid : (state == ST_PAYLOAD && s_axis_tvalid);
  assign skInData      = (state == ST_PREAMBLE) ? {TS_USER, 1'b0, ramQ}
                                                : {s_axis_tuser & ~TS_USER, s_axis_tlast, s_axis_tdata};
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = skOutData;
  // Frame sequencing state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= stateNext;
  end
  // Next state: decide injection at frame start, leave preamble on last TS push, end on payload tlast
  always_comb begin
    stateNext = state;
    stateNext = start                    ? (injDue ? ST_PREAMBLE : ST_PAYLOAD) :
                (push && tsLast)         ? ST_PAYLOAD :
                (beatIn && s_axis_tlast) ? ST_IDLE : state;
  end
  // TS RAM: read-first, so a same-address write lands for the following read only
  always_ff @(posedge ACLK) begin
    if (ts_wr_en) tsRam[ts_wr_addr] <= ts_wr_data;
    if (issue)    ramQ <= tsRam[rdAddr];
  end
  // Config shadows, TS address/rep walk, one-shot tracking, frame counter and error pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      prevMode  <= '0;
      cfg_err   <= 1'b0;
      lenM1     <= '0;
      repsM1    <= '0;
      modeOnce  <= 1'b0;
      rdAddr    <= '0;
      rdRep     <= '0;
      issDone   <= 1'b0;
      tsValid   <= 1'b0;
      tsLast    <= 1'b0;
      onceDone  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      prevMode <= cfg_mode;
      cfg_err  <= start && cfgIllegal;
      if (start) begin
        lenM1    <= AW'(lenClamp - 1'b1);
        repsM1   <= cfg_ts_reps - REP_W'(cfg_ts_reps != '0);
        modeOnce <= cfgMode == TSI_ONCE;
      end
      if (state == ST_IDLE) begin
        rdAddr  <= '0;
        rdRep   <= '0;
        issDone <= 1'b0;
      end else if (issue) begin
        rdAddr  <= atEnd ? '0 : rdAddr + 1'b1;
        rdRep   <= atEnd ? rdRep + 1'b1 : rdRep;
        issDone <= lastWord;
      end
      if (issue) begin
        tsValid <= 1'b1;
        tsLast  <= lastWord;
      end else if (push) begin
        tsValid <= 1'b0;
      end
      if (cfg_mode != prevMode)          onceDone <= 1'b0;
      else if (push && tsLast && modeOnce) onceDone <= 1'b1;
      if (beatIn && s_axis_tlast) frame_cnt <= frame_cnt + 1'b1;
    end
  end
  axis_skid_buf #(.W(SW)) outStage (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .sData   (skInData),
    .sValid  (skInValid),
    .sReady  (skInReady),
    .mData   (skOutData),
    .mValid  (m_axis_tvalid),
    .mReady  (m_axis_tready)
  );
endmodule
